// File: rtl/key_expansion_seq.sv
// Iterative AES-128/192/256 key schedule, one 32-bit word per clock; valid 40/46/52 edges after start.
// No backpressure: starts are ignored while running, and the finished schedule holds until the next accepted start.
module key_expansion_seq (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [1:0]    i_key_len,
    input  logic [255:0]  i_key,
    output logic [1919:0] o_expanded_key,
    output logic [3:0]    o_nr,
    output logic          o_busy,
    output logic          o_valid
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t      state;
    state_t      state_next;
    logic [31:0] w [60];
    logic [5:0]  idx;
    logic [2:0]  phase;
    logic [3:0]  nk;
    logic [7:0]  rcon;

    logic [3:0]  key_nk;
    logic        start_ok;
    logic [5:0]  last_idx;
    logic [31:0] prev_word;
    logic [31:0] old_word;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp;
    logic [31:0] new_word;

    always_comb begin
        case (i_key_len)
            2'd1:    key_nk = 4'd6;
            2'd2:    key_nk = 4'd8;
            default: key_nk = 4'd4;
        endcase
    end

    assign start_ok = i_start && (i_key_len != 2'd3) && (state != RUN);
    // Index of the final word: 4*(NR+1) - 1.
    assign last_idx = {o_nr, 2'b00} + 6'd3;

    // Single word-wide S-box path shared by both substitution cases.
    assign prev_word = w[idx - 6'd1];
    assign old_word  = w[idx - {2'b00, nk}];
    assign sub_in    = (phase == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    assign sub_out   = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]], SBOX[sub_in[15:8]], SBOX[sub_in[7:0]]};

    always_comb begin
        temp = prev_word;
        if (phase == 3'd0)
            temp = sub_out ^ {rcon, 24'h0};
        else if (nk == 4'd8 && phase == 3'd4)
            temp = sub_out;
    end

    assign new_word = old_word ^ temp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start_ok) state_next = RUN;
            RUN:        if (idx == last_idx) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy  = (state == RUN);
        o_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 60; k++) w[k] <= '0;
            idx   <= '0;
            phase <= '0;
            nk    <= '0;
            rcon  <= 8'h01;
            o_nr  <= '0;
        end else if (start_ok) begin
            for (int k = 0; k < 60; k++) w[k] <= '0;
            for (int k = 0; k < 8; k++)
                if (4'(k) < key_nk) w[k] <= i_key[255-32*k -: 32];
            idx   <= {2'b00, key_nk};
            phase <= '0;
            nk    <= key_nk;
            rcon  <= 8'h01;
            o_nr  <= key_nk + 4'd6;
        end else if (state == RUN) begin
            w[idx] <= new_word;
            idx    <= idx + 6'd1;
            phase  <= ({1'b0, phase} == nk - 4'd1) ? 3'd0 : phase + 3'd1;
            if (phase == 3'd0)
                rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
    end

    always_comb begin
        o_expanded_key = '0;
        for (int k = 0; k < 60; k++)
            o_expanded_key[1919-32*k -: 32] = w[k];
    end

endmodule
